// File: rtl/sap1_controller_sequencer.sv
// SAP-1 controller-sequencer: six-state ring counter (T1..T6) with opcode decode.
// The ring moves on the falling edge, so control lines are settled before the rising-edge loads.
module sap1_controller_sequencer #(
    parameter logic [3:0] OP_LDA = 4'b0000,
    parameter logic [3:0] OP_ADD = 4'b0001,
    parameter logic [3:0] OP_SUB = 4'b0010,
    parameter logic [3:0] OP_OUT = 4'b1110,
    parameter logic [3:0] OP_HLT = 4'b1111
) (
    input  logic       clock,
    input  logic       clear,
    input  logic [3:0] opcode,
    output logic       clear_n,
    output logic       cp,
    output logic       ep,
    output logic       lm_n,
    output logic       ce_n,
    output logic       li_n,
    output logic       ei_n,
    output logic       la_n,
    output logic       ea,
    output logic       su,
    output logic       eu,
    output logic       lb_n,
    output logic       lo_n,
    output logic [5:0] t_state,
    output logic       halted
);

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } ring_t;

    typedef struct packed {
        logic cp;
        logic ep;
        logic lm_n;
        logic ce_n;
        logic li_n;
        logic ei_n;
        logic la_n;
        logic ea;
        logic su;
        logic eu;
        logic lb_n;
        logic lo_n;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = 12'b0011_1110_0011;

    ring_t      ring;
    logic [3:0] op_q;
    ctrl_t      ctrl;
    logic       is_lda;
    logic       is_arith;
    logic       is_out;

    // Halt parks the ring at T5 with the halt flag set; only clear releases it.
    always_ff @(negedge clock) begin
        if (clear) begin
            ring   <= T1;
            halted <= 1'b0;
            op_q   <= OP_LDA;
        end else if (!halted) begin
            case (ring)
                T1: ring <= T2;
                T2: ring <= T3;
                T3: begin
                    ring <= T4;
                    op_q <= opcode;
                end
                T4: begin
                    ring <= T5;
                    if (op_q == OP_HLT) halted <= 1'b1;
                end
                T5: ring <= T6;
                T6: ring <= T1;
                default: ring <= T1;
            endcase
        end
    end

    assign is_lda   = (op_q == OP_LDA);
    assign is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);
    assign is_out   = (op_q == OP_OUT);

    always_comb begin
        ctrl = CTRL_IDLE;
        if (!halted) begin
            case (ring)
                T1: begin
                    ctrl.ep   = 1'b1;
                    ctrl.lm_n = 1'b0;
                end
                T2: ctrl.cp = 1'b1;
                T3: begin
                    ctrl.ce_n = 1'b0;
                    ctrl.li_n = 1'b0;
                end
                T4: begin
                    if (is_lda || is_arith) begin
                        ctrl.ei_n = 1'b0;
                        ctrl.lm_n = 1'b0;
                    end else if (is_out) begin
                        ctrl.ea   = 1'b1;
                        ctrl.lo_n = 1'b0;
                    end
                end
                T5: begin
                    if (is_lda) begin
                        ctrl.ce_n = 1'b0;
                        ctrl.la_n = 1'b0;
                    end else if (is_arith) begin
                        ctrl.ce_n = 1'b0;
                        ctrl.lb_n = 1'b0;
                    end
                end
                T6: begin
                    if (is_arith) begin
                        ctrl.eu   = 1'b1;
                        ctrl.la_n = 1'b0;
                        ctrl.su   = (op_q == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

    assign clear_n = ~clear;
    assign cp      = ctrl.cp;
    assign ep      = ctrl.ep;
    assign lm_n    = ctrl.lm_n;
    assign ce_n    = ctrl.ce_n;
    assign li_n    = ctrl.li_n;
    assign ei_n    = ctrl.ei_n;
    assign la_n    = ctrl.la_n;
    assign ea      = ctrl.ea;
    assign su      = ctrl.su;
    assign eu      = ctrl.eu;
    assign lb_n    = ctrl.lb_n;
    assign lo_n    = ctrl.lo_n;
    assign t_state = ring;

    bus_single_driver: assert property (@(posedge clock) disable iff (clear)
        $onehot0({ep, ~ce_n, ~ei_n, ea, eu}));

endmodule
